// File: rtl/sram_nr1w_clr_pkg.sv
// Shared types and helpers for the multi-read, single-write clearable SRAM.
package sram_nr1w_clr_pkg;

  typedef enum logic [0:0] {
    SRAM_CLEAR = 1'b0,
    SRAM_IDLE  = 1'b1
  } sram_state_e;

  // Widest entry the merge helper supports; callers zero-extend and truncate.
  localparam int unsigned MAX_DW = 1024;
  localparam int unsigned MAX_MW = MAX_DW / 8;

  // Number of byte lanes in an entry.
  function automatic int unsigned mask_width(input int unsigned dw);
    return dw / 8;
  endfunction

  // Replace the bytes of old_d selected by mask with the matching bytes of new_d.
  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_d,
                                                   input logic [MAX_DW-1:0] new_d,
                                                   input logic [MAX_MW-1:0] mask);
    logic [MAX_DW-1:0] res;
    res = old_d;
    for (int b = 0; b < int'(MAX_MW); b++) begin
      if (mask[b]) res[8*b +: 8] = new_d[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_nr1w_rdport.sv
// One asynchronous read port: range check, clear masking and write bypass.
module sram_nr1w_rdport
  import sram_nr1w_clr_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 64,
  parameter int unsigned          DATA_DEPTH = 1024,
  parameter int unsigned          BYPASS     = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int unsigned          ADDR_WIDTH = 10,
  parameter int unsigned          MASK_WIDTH = 8
) (
  input  logic                  ready_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic [DATA_WIDTH-1:0] stored_i,
  input  logic                  wr_acc_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [MASK_WIDTH-1:0] wmask_i,
  output logic [DATA_WIDTH-1:0] rdata_c_o
);

  logic in_range_c;
  logic hit_c;

  // Clear hides the array; out-of-range reads return zero; same-address writes forward.
  always_comb begin
    rdata_c_o  = '0;
    in_range_c = 32'(raddr_i) < 32'(DATA_DEPTH);
    hit_c      = (BYPASS != 0) && wr_acc_i && (waddr_i == raddr_i);
    if (!ready_i) begin
      rdata_c_o = INIT_VALUE;
    end else if (!in_range_c) begin
      rdata_c_o = '0;
    end else if (hit_c) begin
      rdata_c_o = DATA_WIDTH'(byte_merge(MAX_DW'(stored_i), MAX_DW'(wdata_i), MAX_MW'(wmask_i)));
    end else begin
      rdata_c_o = stored_i;
    end
  end

endmodule

// File: rtl/sram_nr1w_clr.sv
// Register-file SRAM: RD_PORTS async reads, one byte-masked write, hardware clear engine.
module sram_nr1w_clr
  import sram_nr1w_clr_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           DATA_DEPTH = 1024,
  parameter int unsigned           RD_PORTS   = 2,
  parameter int unsigned           BYPASS     = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int unsigned          ADDR_WIDTH = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
  localparam int unsigned          MASK_WIDTH = mask_width(DATA_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  output logic                           ready,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0] raddr,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rdata,
  input  logic                           ce,
  input  logic                           we,
  input  logic [MASK_WIDTH-1:0]          wmask,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DATA_DEPTH - 1);

  sram_state_e           state_q;
  logic [ADDR_WIDTH-1:0] clr_idx_q;
  logic                  ready_q;
  logic                  wr_acc_c;

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  assign ready    = ready_q;
  assign wr_acc_c = ready_q & ce & we & (32'(waddr) < 32'(DATA_DEPTH));

  // Clear/idle sequencing; ready tracks the idle state one edge after each transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SRAM_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        SRAM_CLEAR: begin
          if (flush) begin
            clr_idx_q <= '0;
          end else if (clr_idx_q == LAST_IDX) begin
            state_q   <= SRAM_IDLE;
            clr_idx_q <= '0;
            ready_q   <= 1'b1;
          end else begin
            clr_idx_q <= clr_idx_q + ADDR_WIDTH'(1);
          end
        end
        SRAM_IDLE: begin
          if (flush) begin
            state_q   <= SRAM_CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
          end
        end
        default: begin
          state_q   <= SRAM_CLEAR;
          clr_idx_q <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  // Storage: clear engine write has priority over the user write port.
  always_ff @(posedge clk) begin
    if (state_q == SRAM_CLEAR) begin
      mem[clr_idx_q] <= INIT_VALUE;
    end else if (wr_acc_c) begin
      mem[waddr] <= DATA_WIDTH'(byte_merge(MAX_DW'(mem[waddr]), MAX_DW'(wdata), MAX_MW'(wmask)));
    end
  end

  // Read ports; the array index is clamped so out-of-range addresses never index past the end.
  for (genvar i = 0; i < int'(RD_PORTS); i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr_c;
    logic [ADDR_WIDTH-1:0] idx_c;
    logic [DATA_WIDTH-1:0] stored_c;

    assign addr_c   = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign idx_c    = (32'(addr_c) < 32'(DATA_DEPTH)) ? addr_c : '0;
    assign stored_c = mem[idx_c];

    sram_nr1w_rdport #(
      .DATA_WIDTH (DATA_WIDTH),
      .DATA_DEPTH (DATA_DEPTH),
      .BYPASS     (BYPASS),
      .INIT_VALUE (INIT_VALUE),
      .ADDR_WIDTH (ADDR_WIDTH),
      .MASK_WIDTH (MASK_WIDTH)
    ) u_rdport (
      .ready_i   (ready_q),
      .raddr_i   (addr_c),
      .stored_i  (stored_c),
      .wr_acc_i  (wr_acc_c),
      .waddr_i   (waddr),
      .wdata_i   (wdata),
      .wmask_i   (wmask),
      .rdata_c_o (rdata[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_sram_nr1w_clr.sv
// Directed bench: three instances (bypass depth 16, no-bypass depth 16, bypass depth 12) share stimulus.
module tb_sram_nr1w_clr;

  localparam logic [63:0] INIT_A = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] INIT_Z = 64'h0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [7:0]   raddr;
  logic         ce, we;
  logic [7:0]   wmask;
  logic [3:0]   waddr;
  logic [63:0]  wdata;
  logic         ready0, ready1, ready2;
  logic [127:0] rdata0, rdata1, rdata2;

  int n_cmp  = 0;
  int n_fail = 0;
  int r0, r1, r2;

  always #5 clk = ~clk;

  sram_nr1w_clr #(.DATA_WIDTH(64), .DATA_DEPTH(16), .RD_PORTS(2), .BYPASS(1), .INIT_VALUE(INIT_A)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ready(ready0), .raddr(raddr), .rdata(rdata0),
    .ce(ce), .we(we), .wmask(wmask), .waddr(waddr), .wdata(wdata));
  sram_nr1w_clr #(.DATA_WIDTH(64), .DATA_DEPTH(16), .RD_PORTS(2), .BYPASS(0), .INIT_VALUE(INIT_A)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ready(ready1), .raddr(raddr), .rdata(rdata1),
    .ce(ce), .we(we), .wmask(wmask), .waddr(waddr), .wdata(wdata));
  sram_nr1w_clr #(.DATA_WIDTH(64), .DATA_DEPTH(12), .RD_PORTS(2), .BYPASS(1), .INIT_VALUE(INIT_Z)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ready(ready2), .raddr(raddr), .rdata(rdata2),
    .ce(ce), .we(we), .wmask(wmask), .waddr(waddr), .wdata(wdata));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count edges until each ready rises, bounded; 0 means it never rose.
  task automatic wait_ready(input int limit);
    r0 = 0; r1 = 0; r2 = 0;
    for (int c = 1; c <= limit; c++) begin
      tick();
      if (ready0 && r0 == 0) r0 = c;
      if (ready1 && r1 == 0) r1 = c;
      if (ready2 && r2 == 0) r2 = c;
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; raddr = 8'h10; ce = 1'b0; we = 1'b0;
    wmask = 8'h00; waddr = 4'd0; wdata = 64'h0;
    #1;
    // In reset: not ready, reads show INIT_VALUE
    check("reset_ready0", 64'(ready0), 64'd0);
    check("reset_rdata_u0", rdata0[63:0], INIT_A);
    check("reset_rdata_u2", rdata2[63:0], INIT_Z);
    tick(); tick();

    // Release; attempt a write to addr 2 during the first clear cycles
    rst_n = 1'b1;
    ce = 1'b1; we = 1'b1; waddr = 4'd2; wdata = 64'hFFFF_FFFF_FFFF_FFFF; wmask = 8'hFF;
    tick(); tick();
    check("clear_ready0_low", 64'(ready0), 64'd0);
    check("clear_read_init", rdata0[63:0], INIT_A);
    we = 1'b0;
    wait_ready(18);
    check("rel_cycles_u0", 64'(r0), 64'd14);
    check("rel_cycles_u1", 64'(r1), 64'd14);
    check("rel_cycles_u2", 64'(r2), 64'd10);
    // r counted from the third edge after release: 16 and 12 edges total

    for (int a = 0; a < 16; a++) begin
      raddr = {4'd0, 4'(a)};
      #1;
      check($sformatf("post_reset_u0[%0d]", a), rdata0[63:0], INIT_A);
    end
    raddr = 8'h22;
    #1;
    check("dropped_write_addr2", rdata0[63:0], INIT_A);
    check("dropped_write_addr2_p1", rdata0[127:64], INIT_A);

    // Full zero write to 3, then partial write of low four bytes
    ce = 1'b1; we = 1'b1; waddr = 4'd3; wdata = 64'h0; wmask = 8'hFF;
    tick();
    wdata = 64'h1122_3344_5566_7788; wmask = 8'h0F; raddr = 8'h33;
    #1;
    check("partial_bypass_u0", rdata0[127:64], 64'h0000_0000_5566_7788);
    check("partial_nobypass_u1", rdata1[127:64], 64'h0);
    tick();
    we = 1'b0;
    #1;
    check("partial_u0", rdata0[63:0], 64'h0000_0000_5566_7788);
    check("partial_u1", rdata1[63:0], 64'h0000_0000_5566_7788);
    check("partial_u2", rdata2[63:0], 64'h0000_0000_5566_7788);

    // Same-cycle bypass on addr 5
    we = 1'b1; waddr = 4'd5; wdata = 64'hDEAD; wmask = 8'hFF; raddr = 8'h55;
    #1;
    check("bypass_u0_p0", rdata0[63:0], 64'hDEAD);
    check("bypass_u0_p1", rdata0[127:64], 64'hDEAD);
    check("nobypass_u1_old", rdata1[63:0], INIT_A);
    tick();
    we = 1'b0;
    #1;
    check("nobypass_u1_new", rdata1[63:0], 64'hDEAD);

    // Zero mask is a no-op both in bypass and storage
    we = 1'b1; wdata = 64'hFFFF_FFFF_FFFF_FFFF; wmask = 8'h00;
    #1;
    check("nomask_bypass_u0", rdata0[63:0], 64'hDEAD);
    tick();
    we = 1'b0;
    #1;
    check("nomask_store_u0", rdata0[63:0], 64'hDEAD);

    // Out-of-range write/read on the depth-12 instance
    we = 1'b1; waddr = 4'd13; wdata = 64'h1234; wmask = 8'hFF; raddr = 8'h1D;
    #1;
    check("oor_bypass_u2", rdata2[63:0], 64'h0);
    tick();
    we = 1'b0;
    #1;
    check("oor_read_u2", rdata2[63:0], 64'h0);
    check("inrange_13_u0", rdata0[63:0], 64'h1234);
    check("oor_no_alias_u2", rdata2[127:64], 64'h0);

    // Flush, then flush again five cycles into the clear
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ready_drop", 64'(ready0), 64'd0);
    raddr = 8'h33;
    #1;
    check("flush_read_init", rdata0[63:0], INIT_A);
    for (int k = 0; k < 5; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_ready(20);
    check("reflush_cycles_u0", 64'(r0), 64'd16);
    check("reflush_cycles_u2", 64'(r2), 64'd12);
    for (int a = 0; a < 16; a++) begin
      raddr = {4'(a), 4'(a)};
      #1;
      check($sformatf("post_flush_u0[%0d]", a), rdata0[63:0], INIT_A);
      check($sformatf("post_flush_u1[%0d]", a), rdata1[127:64], INIT_A);
      if (a < 12) check($sformatf("post_flush_u2[%0d]", a), rdata2[63:0], INIT_Z);
    end

    // Reset in the middle of a clear restarts a full clear
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midclear_rst_ready", 64'(ready0), 64'd0);
    tick();
    rst_n = 1'b1;
    wait_ready(20);
    check("midclear_rel_u0", 64'(r0), 64'd16);
    check("midclear_rel_u2", 64'(r2), 64'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_nr1w_clr.md
# sram_nr1w_clr

Parametrised multi-read-port, single-write-port register-file SRAM with asynchronous reads, byte-masked writes, optional write-to-read bypass, and a built-in hardware clear engine. It is the next-generation storage primitive for tag/valid arrays, predictor tables and register files in the core. Those arrays need a known state after reset or flush without software initialisation, and need same-cycle visibility of in-flight writes.

## Interface
Parameters:
- DATA_WIDTH, 64, bits per entry; must be a multiple of 8.
- DATA_DEPTH, 1024, number of entries; need not be a power of two.
- RD_PORTS, 2, number of independent asynchronous read ports, 1..8.
- BYPASS, 1, 1 = read data forwards same-cycle write data; 0 = read returns stored array contents only.
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every entry by the clear engine.

Derived values:
- ADDR_WIDTH = $clog2(DATA_DEPTH).
- MASK_WIDTH = DATA_WIDTH/8.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  request to re-clear the whole array to INIT_VALUE.
- ready  out  1  high when the array is usable and writes are accepted.
- raddr  in  RD_PORTS*ADDR_WIDTH  read addresses; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  RD_PORTS*DATA_WIDTH  read data, packed the same way as raddr.
- ce  in  1  chip enable for the write port.
- we  in  1  write enable.
- wmask  in  MASK_WIDTH  byte write enables; bit b covers bits [8b+7:8b].
- waddr  in  ADDR_WIDTH  write address.
- wdata  in  DATA_WIDTH  write data.

## Operation
- FSM states:
  - CLEAR: counter clr_idx writes INIT_VALUE to entry clr_idx, one entry per cycle.
  - IDLE: normal operation.
- Reset (rst_n=0): state=CLEAR, clr_idx=0, ready=0. Array contents are not touched asynchronously; the clear engine overwrites them after release.
- CLEAR → IDLE on the cycle where clr_idx==DATA_DEPTH-1. ready rises on the following cycle.
- IDLE → CLEAR when flush=1. clr_idx is set to 0 and ready drops the next cycle.
- flush=1 while in CLEAR restarts clr_idx at 0.
- Write acceptance: the write is accepted when ready & ce & we & (waddr < DATA_DEPTH). Only bytes with wmask[b]=1 are updated. wmask=0 is a legal no-op.
- While ready=0, user writes are silently dropped; the clear write has priority.
- Reads are combinational from raddr for every port:
  - raddr ≥ DATA_DEPTH returns 0.
  - While ready=0, every port returns INIT_VALUE, so consumers never see stale data during a clear.
- Bypass (BYPASS=1): if an accepted write targets the same address as read port i in the same cycle, rdata[i] = stored data with bytes replaced by wdata where wmask=1.
- Without bypass (BYPASS=0): rdata shows the new value only after the write edge.
- Multiple read ports at the same address return identical data.

## Timing
- Read latency is 0 cycles (combinational). The path raddr→rdata passes through one comparator per port when BYPASS=1.
- Write latency is 1 cycle. The array is updated at the rising edge after the accepted request.
- Clear duration is exactly DATA_DEPTH cycles from rst_n release or from the flush edge. ready=1 on cycle DATA_DEPTH+1.
- Reset values: ready=0, state=CLEAR, clr_idx=0. rdata reads as INIT_VALUE while in reset.
- Reset asserted mid-clear aborts the clear; a full clear restarts on release.
- clr_idx is ADDR_WIDTH bits wide and must not wrap past DATA_DEPTH-1 for non-power-of-two depths.

## Structure
- A shared package holds:
  - the state enum type (SRAM_CLEAR, SRAM_IDLE);
  - the function computing MASK_WIDTH;
  - a byte-merge function (old, new, mask) → merged data, reused for the write path and the bypass path.
- One natural sub-module: sram_nr1w_rdport, which handles address range check, bypass compare/merge and clear masking for one read port. It is instantiated RD_PORTS times in a generate loop.
- Storage is a plain reg array written in a single always block, so synthesis infers distributed RAM.

## Test plan
- Reset release, DATA_DEPTH=16: ready=0 for 16 cycles then 1. Every entry reads INIT_VALUE=64'hA5A5_A5A5_A5A5_A5A5.
- Write addr 3, wdata 64'h1122334455667788, wmask 8'h0F, onto 64'h0 → next cycle raddr=3 reads 64'h0000000055667788.
- BYPASS=1: port0 raddr=5 in the same cycle as a full-mask write to 5 of 64'hDEAD → rdata0 shows 64'hDEAD combinationally. BYPASS=0 shows the old value until the edge.
- Write attempted while ready=0 (during clear), addr 2 → after clear, addr 2 reads INIT_VALUE.
- flush pulsed mid-operation with entries written, then again 5 cycles into the clear → ready low, clr_idx restarts, ready returns exactly 16 cycles after the second flush, all entries read INIT_VALUE.
- DATA_DEPTH=12: write to addr 13 is ignored, raddr=13 reads 0. The clear ends at index 11 without wrapping.
